vend_change_tx: RTL

- Change/refund transmitter for the vending datapath.
- Converts a requested payout amount, in half-yuan units, into a serial stream of coin codes on a 2-bit coin bus.
- Uses the same coin encoding as the vending FSMs' D_in: 2'b01 = 0.5 yuan, 2'b10 = 1 yuan, 2'b00 = no coin.
- Sits between the vending controller (source of the change amount) and the coin hopper, or a loopback into a vending FSM for test.

---
 rtl/vend_change_tx_if.sv | 23 ++
 rtl/vend_change_tx.sv | 102 ++++++++++
 2 files changed

// File: rtl/vend_change_tx_if.sv
// rtl/vend_change_tx_if.sv - coin payout request/response bundle between controller and change transmitter
interface vend_change_tx_if #(
    parameter int AMT_W = 4
);
    logic             Start;
    logic [AMT_W-1:0] Amount;
    logic             One_empty;
    logic             Hold;
    logic [1:0]       D_out;
    logic             Busy;
    logic             Done;
    logic [AMT_W-1:0] Remain;

    modport master (
        output Start, Amount, One_empty, Hold,
        input  D_out, Busy, Done, Remain
    );

    modport slave (
        input  Start, Amount, One_empty, Hold,
        output D_out, Busy, Done, Remain
    );
endinterface

// File: rtl/vend_change_tx.sv
// rtl/vend_change_tx.sv - serialises a half-yuan payout amount into 2-bit coin codes
module vend_change_tx #(
    parameter int AMT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    vend_change_tx_if.slave  bus
);
    localparam int CNT_W = (GAP >= 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dout;
    logic             r_busy;
    logic             r_done;
    logic [AMT_W-1:0] r_remain;

    logic             w_use_one;
    logic [1:0]       w_coin;
    logic [AMT_W-1:0] w_remain_next;

    // A 1-yuan coin needs both stock and at least two half-units left, so Remain can never underflow.
    assign w_use_one     = (r_remain > AMT_W'(1)) && !bus.One_empty;
    assign w_coin        = w_use_one ? COIN_ONE : COIN_HALF;
    assign w_remain_next = w_use_one ? (r_remain - AMT_W'(2)) : (r_remain - AMT_W'(1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dout   <= COIN_NONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_remain <= '0;
        end else begin
            r_dout <= COIN_NONE;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        if (bus.Amount != '0) begin
                            r_remain <= bus.Amount;
                            r_busy   <= 1'b1;
                            r_state  <= S_SEND;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SEND: begin
                    if (!bus.Hold) begin
                        r_dout   <= w_coin;
                        r_remain <= w_remain_next;
                        if (w_remain_next == '0) begin
                            r_state <= S_DONE;
                        end else if (GAP == 0) begin
                            r_state <= S_SEND;
                        end else begin
                            r_cnt   <= GAP_LD;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // Leaving on count 1 puts the next coin GAP+1 edges after the previous one.
                    if (r_cnt <= CNT_ONE) begin
                        r_cnt   <= '0;
                        r_state <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.D_out  = r_dout;
    assign bus.Busy   = r_busy;
    assign bus.Done   = r_done;
    assign bus.Remain = r_remain;
endmodule
